// File: rtl/gray_conv_sched_if.sv
// Request/response bundle for gray_conv_sched: four Gray-word requesters in,
// one tagged binary result out.
interface gray_conv_sched_if #(
  parameter int WIDTH = 4
) ();
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_gray;
  logic [3:0]         req_ready;
  logic               rsp_valid;
  logic [WIDTH-1:0]   rsp_binary;
  logic [1:0]         rsp_id;
  logic               rsp_ready;

  modport master (
    output req_valid, req_gray, rsp_ready,
    input  req_ready, rsp_valid, rsp_binary, rsp_id
  );

  modport slave (
    input  req_valid, req_gray, rsp_ready,
    output req_ready, rsp_valid, rsp_binary, rsp_id
  );
endinterface

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one registered Gray-to-binary converter among
// four requesters. Define GRAY_SCHED_FAST_EN to convert in the accept cycle.
module gray_conv_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  gray_conv_sched_if.slave bus,
  output logic             busy,
  output logic [7:0]       conv_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_ptr;
  logic [1:0]       r_id_q;
  logic [WIDTH-1:0] r_bin_q;
  logic [7:0]       r_count;
`ifndef GRAY_SCHED_FAST_EN
  logic [WIDTH-1:0] r_gray_q;
`endif

  logic             w_grant_any;
  logic [1:0]       w_grant_id;
  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_sel_gray;
  logic [3:0]       w_req_ready;
  logic             w_accept;
  logic             w_rsp_hs;

  // Prefix XOR from the MSB down: each binary bit folds in all higher Gray bits.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
    end
    return b;
  endfunction

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_grant_any && bus.req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_gray = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_grant_id == 2'(i)) w_sel_gray = bus.req_gray[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates the grant so req_ready stays low while reset is held.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_any && rst_n) begin
          w_req_ready[w_grant_id] = 1'b1;
          w_accept                = 1'b1;
`ifdef GRAY_SCHED_FAST_EN
          w_next = RESP;
`else
          w_next = CONV;
`endif
        end
      end
      CONV: w_next = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_hs = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_id_q   <= '0;
      r_bin_q  <= '0;
      r_count  <= '0;
`ifndef GRAY_SCHED_FAST_EN
      r_gray_q <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id_q <= w_grant_id;
`ifdef GRAY_SCHED_FAST_EN
        r_bin_q <= gray2bin(w_sel_gray);
`else
        r_gray_q <= w_sel_gray;
`endif
      end
`ifndef GRAY_SCHED_FAST_EN
      if (r_state == CONV) r_bin_q <= gray2bin(r_gray_q);
`endif
      if (w_rsp_hs) begin
        r_count <= r_count + 8'd1;
        r_ptr   <= r_id_q + 2'd1;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_binary = (r_state == RESP) ? r_bin_q : '0;
  assign bus.rsp_id     = (r_state == RESP) ? r_id_q : '0;
  assign busy           = (r_state != IDLE);
  assign conv_count     = r_count;

endmodule
